// File: rtl/tm_infer_pkg.sv
// Shared types and sizing helpers for the sequential inference controller.
// Default-derived constants describe the reference configuration. Modules
// recompute the same values from their own parameters with the helper functions.
package tm_infer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUM    = 2'd1,
    ARGMAX = 2'd2,
    OUT    = 2'd3
  } tm_state_t;

  // Clauses owned by each class
  function automatic int calc_p(input int clause_num, input int class_num);
    return clause_num / class_num;
  endfunction

  // Number of SUM cycles needed to walk one class
  function automatic int calc_k(input int clause_num, input int class_num, input int chunk);
    return (clause_num / class_num) / chunk;
  endfunction

  // Index width that stays at least one bit wide
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_STAGE_NUM  = 13;
  localparam int DEF_CLAUSE_NUM = 200;
  localparam int DEF_CLASS_NUM  = 10;
  localparam int DEF_CHUNK      = 10;

  localparam int P     = calc_p(DEF_CLAUSE_NUM, DEF_CLASS_NUM);
  localparam int K     = calc_k(DEF_CLAUSE_NUM, DEF_CLASS_NUM, DEF_CHUNK);
  localparam int CNT_W = idx_width(DEF_STAGE_NUM);
  localparam int CHK_W = idx_width(K);
  localparam int IDX_W = idx_width(DEF_CLASS_NUM);

endpackage

// File: rtl/tm_infer_seq_ctrl_argmax.sv
// Sequential signed argmax over the class sums. One class is examined per
// cycle from index 0 upward. Only a strictly greater value replaces the
// current best, so ties resolve to the lowest index.
module tm_class_argmax
  import tm_infer_pkg::*;
#(
  parameter int CLASS_NUM     = 10,
  parameter int WEIGHT_LENGTH = 9,
  localparam int IW           = idx_width(CLASS_NUM)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [CLASS_NUM-1:0][WEIGHT_LENGTH-1:0]  sums,
  output logic                                     done,
  output logic [IW-1:0]                            best_idx
);

  logic                            running_reg;
  logic [IW-1:0]                   idx_reg;
  logic signed [WEIGHT_LENGTH-1:0] best_reg;
  logic [IW-1:0]                   best_idx_reg;
  logic signed [WEIGHT_LENGTH-1:0] cur;

  assign cur      = $signed(sums[idx_reg]);
  assign done     = running_reg && (idx_reg == IW'(CLASS_NUM - 1));
  assign best_idx = best_idx_reg;

  // Scan register: restart on start, otherwise step one class per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_reg  <= 1'b0;
      idx_reg      <= '0;
      best_reg     <= '0;
      best_idx_reg <= '0;
    end else if (start) begin
      running_reg <= 1'b1;
      idx_reg     <= '0;
    end else if (running_reg) begin
      if ((idx_reg == '0) || (cur > best_reg)) begin
        best_reg     <= cur;
        best_idx_reg <= idx_reg;
      end
      if (done) running_reg <= 1'b0;
      else      idx_reg     <= idx_reg + 1'b1;
    end
  end

endmodule

// File: rtl/tm_infer_seq_ctrl.sv
// Inference top-level control: sequences input beats into the HCB chain,
// accumulates signed class sums from a clause snapshot, runs an argmax and
// returns the winning class over AXI-Stream.
// Optional build macro TM_OVERLAP_EN: keeps the input open while the engine
// works so the next sample can load, holding only its final beat back.
module tm_infer_seq_ctrl
  import tm_infer_pkg::*;
#(
  parameter int STAGE_NUM              = 13,
  parameter int CLAUSE_NUM             = 200,
  parameter int CLASS_NUM              = 10,
  parameter int WEIGHT_LENGTH          = 9,
  parameter int CHUNK                  = 10,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  output logic [STAGE_NUM-1:0]                  stage_valid,
  input  logic [CLAUSE_NUM-1:0]                 clauses,
  output logic [CLASS_NUM*WEIGHT_LENGTH-1:0]    class_sums,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tlast,
  output logic                                  busy
);

  localparam int PER_CLASS  = calc_p(CLAUSE_NUM, CLASS_NUM);
  localparam int NUM_CHUNKS = calc_k(CLAUSE_NUM, CLASS_NUM, CHUNK);
  localparam int CW         = idx_width(STAGE_NUM);
  localparam int KW         = idx_width(NUM_CHUNKS);
  localparam int IW         = idx_width(CLASS_NUM);
  localparam logic signed [WEIGHT_LENGTH-1:0] W_ONE = WEIGHT_LENGTH'(1);

  // Static parameter checks
  if ((CLAUSE_NUM % CLASS_NUM) != 0) begin : g_chk_class
    $error("CLAUSE_NUM must be a multiple of CLASS_NUM");
  end
  if ((PER_CLASS % CHUNK) != 0) begin : g_chk_chunk
    $error("CHUNK must divide CLAUSE_NUM/CLASS_NUM");
  end
  if (((2 ** (WEIGHT_LENGTH - 1)) - 1) < (PER_CLASS / 2)) begin : g_chk_width
    $error("WEIGHT_LENGTH too narrow for the class sum range");
  end

  tm_state_t                              state_reg, state_next;
  logic [CW-1:0]                          cnt_reg;
  logic                                   accepted, final_beat, pending_reg;
  logic                                   tlast_acc_reg, tlast_beat_reg, tlast_out_reg;
  logic [CLAUSE_NUM-1:0]                  snap_reg;
  logic [KW-1:0]                          chunk_reg;
  logic [CLASS_NUM-1:0][WEIGHT_LENGTH-1:0] sums_reg, sums_upd;
  logic                                   sum_last, argmax_done;
  logic [IW-1:0]                          best_idx;

  assign final_beat = (cnt_reg == CW'(STAGE_NUM - 1));
  assign accepted   = s_axis_tvalid & s_axis_tready;
  assign sum_last   = (state_reg == SUM) && (chunk_reg == KW'(NUM_CHUNKS - 1));
  assign class_sums = sums_reg;

`ifdef TM_OVERLAP_EN
  // Early beats always load; the final one waits until the engine is free
  assign s_axis_tready = ~rst & (~final_beat | (state_reg == IDLE) |
                                 ((state_reg == OUT) & m00_axis_tready));
`else
  assign s_axis_tready = ~rst & (state_reg == IDLE);
`endif

  genvar gi;
  for (gi = 0; gi < STAGE_NUM; gi++) begin : g_stage
    assign stage_valid[gi] = accepted & (cnt_reg == CW'(gi));
  end

  // Beat counter, final-beat pulse and sticky TLAST tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      pending_reg    <= 1'b0;
      tlast_acc_reg  <= 1'b0;
      tlast_beat_reg <= 1'b0;
    end else begin
      pending_reg <= accepted & final_beat;
      if (accepted) begin
        if (final_beat) begin
          cnt_reg        <= '0;
          tlast_beat_reg <= tlast_acc_reg | s_axis_tlast;
          tlast_acc_reg  <= 1'b0;
        end else begin
          cnt_reg       <= cnt_reg + 1'b1;
          tlast_acc_reg <= tlast_acc_reg | s_axis_tlast;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (pending_reg)     state_next = SUM;
      SUM:     if (sum_last)        state_next = ARGMAX;
      ARGMAX:  if (argmax_done)     state_next = OUT;
      OUT:     if (m00_axis_tready) state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // FSM outputs: result is driven only while presenting it
  always_comb begin
    m00_axis_tvalid = (state_reg == OUT);
    m00_axis_tdata  = '0;
    m00_axis_tlast  = 1'b0;
    if (state_reg == OUT) begin
      m00_axis_tdata = C_M00_AXIS_TDATA_WIDTH'(best_idx);
      m00_axis_tlast = tlast_out_reg;
    end
    busy = (state_reg != IDLE);
  end

  // Per-class signed popcount of the current chunk (even offset +1, odd -1)
  for (gi = 0; gi < CLASS_NUM; gi++) begin : g_class
    logic [CHUNK-1:0]                chunk_bits;
    logic signed [WEIGHT_LENGTH-1:0] delta;
    assign chunk_bits = snap_reg[gi*PER_CLASS + int'(chunk_reg)*CHUNK +: CHUNK];
    always_comb begin
      delta = '0;
      for (int j = 0; j < CHUNK; j++) begin
        if (chunk_bits[j]) begin
          if (((int'(chunk_reg) * CHUNK + j) % 2) == 0) delta = delta + W_ONE;
          else                                          delta = delta - W_ONE;
        end
      end
    end
    assign sums_upd[gi] = sums_reg[gi] + delta;
  end

  // Snapshot and accumulation: clear on SUM entry, add one chunk per SUM cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_reg      <= '0;
      chunk_reg     <= '0;
      sums_reg      <= '0;
      tlast_out_reg <= 1'b0;
    end else if ((state_reg == IDLE) && pending_reg) begin
      snap_reg      <= clauses;
      chunk_reg     <= '0;
      sums_reg      <= '0;
      tlast_out_reg <= tlast_beat_reg;
    end else if (state_reg == SUM) begin
      chunk_reg <= chunk_reg + 1'b1;
      sums_reg  <= sums_upd;
    end
  end

  tm_class_argmax #(
    .CLASS_NUM     (CLASS_NUM),
    .WEIGHT_LENGTH (WEIGHT_LENGTH)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .start    (sum_last),
    .sums     (sums_reg),
    .done     (argmax_done),
    .best_idx (best_idx)
  );

endmodule

// File: tb/tb_tm_infer_seq_ctrl.sv
// Self-checking bench for tm_infer_seq_ctrl with a result scoreboard.
module tb_tm_infer_seq_ctrl;

  localparam int STAGE_NUM  = 13;
  localparam int CLAUSE_NUM = 200;
  localparam int CLASS_NUM  = 10;
  localparam int W          = 9;
  localparam int CHUNK      = 10;
  localparam int DW         = 64;
  localparam int P          = CLAUSE_NUM / CLASS_NUM;
  localparam int LAT        = P / CHUNK + CLASS_NUM + 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    s_axis_tvalid = 1'b0;
  logic                    s_axis_tready;
  logic                    s_axis_tlast = 1'b0;
  logic [STAGE_NUM-1:0]    stage_valid;
  logic [CLAUSE_NUM-1:0]   clauses = '0;
  logic [CLASS_NUM*W-1:0]  class_sums;
  logic [DW-1:0]           m00_axis_tdata;
  logic                    m00_axis_tvalid;
  logic                    m00_axis_tready = 1'b0;
  logic                    m00_axis_tlast;
  logic                    busy;

  always #5 clk = ~clk;

  tm_infer_seq_ctrl #(
    .STAGE_NUM(STAGE_NUM), .CLAUSE_NUM(CLAUSE_NUM), .CLASS_NUM(CLASS_NUM),
    .WEIGHT_LENGTH(W), .CHUNK(CHUNK), .C_M00_AXIS_TDATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .stage_valid(stage_valid), .clauses(clauses),
    .class_sums(class_sums), .m00_axis_tdata(m00_axis_tdata),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tready(m00_axis_tready),
    .m00_axis_tlast(m00_axis_tlast), .busy(busy)
  );

  typedef struct {
    int                     idx;
    logic                   tlast;
    logic [CLASS_NUM*W-1:0] sums;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   fc       = 0;
  int   bcnt     = 0;
  int   busy_acc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed class sums and lowest-index strict argmax
  function automatic exp_t model(input logic [CLAUSE_NUM-1:0] pat, input logic tl);
    exp_t e;
    int   s, best, bi;
    e.sums = '0; e.tlast = tl; best = 0; bi = 0;
    for (int c = 0; c < CLASS_NUM; c++) begin
      s = 0;
      for (int o = 0; o < P; o++)
        if (pat[c*P+o]) s += ((o % 2) == 0) ? 1 : -1;
      e.sums[c*W +: W] = W'(s);
      if ((c == 0) || (s > best)) begin best = s; bi = c; end
    end
    e.idx = bi;
    return e;
  endfunction

  // Gives class c a sum of s by setting even (positive) or odd (negative) clauses
  function automatic logic [CLAUSE_NUM-1:0] set_cls(input logic [CLAUSE_NUM-1:0] base,
                                                    input int c, input int s);
    logic [CLAUSE_NUM-1:0] r;
    r = base;
    for (int o = 0; o < P; o++) r[c*P+o] = 1'b0;
    if (s >= 0) for (int k = 0; k < s; k++)  r[c*P+2*k]   = 1'b1;
    else        for (int k = 0; k < -s; k++) r[c*P+2*k+1] = 1'b1;
    return r;
  endfunction

  task automatic send_sample(input logic [CLAUSE_NUM-1:0] pat, input int tlast_beat);
    bit ok;
    int guard;
    for (int b = 0; b < STAGE_NUM; b++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == tlast_beat);
      if (b == STAGE_NUM - 1) begin
        clauses = pat;
        exp_q.push_back(model(pat, tlast_beat >= 0));
      end
      ok = 1'b0; guard = 0;
      while (!ok) begin
        #4; ok = s_axis_tready;
        @(posedge clk);
        if (!ok) begin
          guard++;
          if (guard > 300) begin
            check("beat_accept_timeout", s_axis_tready, 1);
            return;
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle_input();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0) || busy || m00_axis_tvalid) begin
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        check("drain_timeout", busy, 0);
        return;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor just before each rising edge
  logic          prev_tv = 1'b0, prev_tr = 1'b0;
  logic [DW-1:0] prev_td = '0;
  always begin
    logic [STAGE_NUM-1:0] ev;
    logic                 acc;
    exp_t                 e;
    @(negedge clk);
    #4;
    if (rst) begin
      bcnt = 0; prev_tv = 1'b0; prev_tr = 1'b0;
    end else begin
      acc = s_axis_tvalid && s_axis_tready;
      ev  = '0;
      if (acc) ev[bcnt] = 1'b1;
      check("stage_valid", stage_valid, ev);
`ifndef TM_OVERLAP_EN
      if (busy) check("s_tready_while_busy", s_axis_tready, 0);
`endif
      if (acc) begin
`ifdef TM_OVERLAP_EN
        if (busy) busy_acc++;
        if (busy && (bcnt == STAGE_NUM - 1))
          check("final_beat_needs_out_handshake", m00_axis_tvalid && m00_axis_tready, 1);
`endif
        if (bcnt == STAGE_NUM - 1) begin fc = cyc; bcnt = 0; end
        else bcnt++;
      end
      if (m00_axis_tvalid && !prev_tv) check("latency", cyc - fc - 1, LAT);
      if (prev_tv && !prev_tr) begin
        check("tvalid_hold", m00_axis_tvalid, 1);
        check("tdata_hold", m00_axis_tdata, prev_td);
      end
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("spurious_tvalid", m00_axis_tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          $display("result tdata=%0d tlast=%0d exp_idx=%0d exp_tlast=%0d",
                   m00_axis_tdata, m00_axis_tlast, e.idx, e.tlast);
          check("tdata", m00_axis_tdata, e.idx);
          check("tlast", m00_axis_tlast, e.tlast);
          for (int c = 0; c < CLASS_NUM; c++)
            check("class_sums", class_sums[c*W +: W], e.sums[c*W +: W]);
        end
      end
      prev_tv = m00_axis_tvalid;
      prev_tr = m00_axis_tready;
      prev_td = m00_axis_tdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_s_tready"},  s_axis_tready, 0);
    check({tag, "_tvalid"},    m00_axis_tvalid, 0);
    check({tag, "_tdata"},     m00_axis_tdata, 0);
    check({tag, "_tlast"},     m00_axis_tlast, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_stage"},     stage_valid, 0);
    check({tag, "_sums_lo"},   class_sums[63:0], 0);
    check({tag, "_sums_hi"},   64'(class_sums[CLASS_NUM*W-1:64]), 0);
  endtask

  initial begin
    logic [CLAUSE_NUM-1:0] pat, pat2;
    int guard;

    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m00_axis_tready = 1'b1;

    // Single positive class
    send_sample(set_cls('0, 3, 10), -1);
    idle_input(); drain();

    // Tie between classes 2 and 7 resolves low
    send_sample(set_cls(set_cls('0, 2, 5), 7, 5), -1);
    idle_input(); drain();

    // All negative, signed comparison picks the least negative
    pat = '0;
    for (int c = 0; c < CLASS_NUM; c++) pat = set_cls(pat, c, -4);
    pat = set_cls(set_cls(pat, 0, -3), 5, -1);
    send_sample(pat, -1);
    idle_input(); drain();

    // Backpressure for 20 cycles
    m00_axis_tready = 1'b0;
    send_sample(set_cls(set_cls('0, 1, 3), 8, 7), -1);
    idle_input();
    guard = 0;
    while (!m00_axis_tvalid && guard < 100) begin @(negedge clk); guard++; end
    check("bp_tvalid_seen", m00_axis_tvalid, 1);
    repeat (20) @(negedge clk);
    m00_axis_tready = 1'b1;
    drain();

    // TLAST on beat 4 of the second sample only
    send_sample(set_cls('0, 4, 2), -1);
    send_sample(set_cls('0, 6, 9), 4);
    idle_input(); drain();

    // Reset during the first SUM cycle aborts the sample
    send_sample(set_cls('0, 1, 4), -1);
    idle_input();
    guard = 0;
    while (!busy && guard < 50) begin @(negedge clk); guard++; end
    check("sum_entry_seen", busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    send_sample(set_cls('0, 9, 6), -1);
    idle_input(); drain();

`ifdef TM_OVERLAP_EN
    // Back-to-back samples with continuous valid
    busy_acc = 0;
    pat  = set_cls('0, 5, 8);
    pat2 = set_cls(set_cls('0, 0, 2), 2, -3);
    send_sample(pat, -1);
    send_sample(pat2, 0);
    idle_input(); drain();
    check("overlap_beats_while_busy", busy_acc, STAGE_NUM - 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm_infer_seq_ctrl.md
Name: tm_infer_seq_ctrl

Overview:
- Parametrised successor to the hard-coded inference top-level control.
- Drives one-hot stage valids to the STAGE_NUM HCB chain from an AXI-Stream input handshake.
- Accumulates signed class sums sequentially from the final clause vector, then runs a sequential argmax.
- Returns the predicted class on an AXI-Stream master with full backpressure and TLAST propagation.
- Replaces the ad-hoc adder/argmax/finish flags with one reset-safe FSM.

Parameters:
- STAGE_NUM, 13: HCB stages, i.e. input beats per sample.
- CLAUSE_NUM, 200: total clauses; must be a multiple of CLASS_NUM.
- CLASS_NUM, 10: number of classes.
- WEIGHT_LENGTH, 9: signed class-sum width; must hold ±CLAUSE_NUM/(2*CLASS_NUM).
- CHUNK, 10: clauses per class summed per cycle; must divide CLAUSE_NUM/CLASS_NUM.
- C_M00_AXIS_TDATA_WIDTH, 64: output data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_axis_tvalid  in  1  input beat valid (data goes directly to the HCBs).
- s_axis_tready  out  1  block accepts a beat.
- s_axis_tlast  in  1  last sample of a frame.
- stage_valid  out  STAGE_NUM  one-hot load strobe to HCB i.
- clauses  in  CLAUSE_NUM  final HCB partial_clause output.
- class_sums  out  CLASS_NUM x WEIGHT_LENGTH signed  latest class sums.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  zero-extended class index.
- m00_axis_tvalid  out  1  result valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tlast  out  1  frame end.
- busy  out  1  engine not in IDLE.

Behaviour:
- Reset: all outputs are 0.
  - FSM goes to IDLE; beat counter 0; class_sums 0; captured tlast 0.
  - Reset mid-operation aborts the sample; no partial result is emitted.
- Beat counter and stage valids:
  - A beat is accepted on s_axis_tvalid & s_axis_tready.
  - stage_valid[i] = accepted & (cnt == i), combinational.
  - cnt wraps STAGE_NUM-1 -> 0.
- TLAST capture: tlast is captured sticky if s_axis_tlast is seen on any beat of the sample; it is transferred to the engine on the final beat.
- Clause layout: class c owns clauses [c*P, (c+1)*P), where P = CLAUSE_NUM/CLASS_NUM. Even offset is +1, odd offset is -1.
- FSM states: IDLE -> SUM -> ARGMAX -> OUT -> IDLE.
  - IDLE -> SUM: on the cycle after the final beat is accepted. The clause vector is captured into a snapshot register on the SUM entry cycle.
  - SUM: K = P/CHUNK cycles. Each cycle adds the signed popcount of CHUNK clauses per class into class_sums. Sums are cleared on SUM entry.
  - ARGMAX: CLASS_NUM cycles, scanning index 0 upward.
    - A strictly greater sum replaces the best, so ties go to the lowest index.
    - Comparison is signed.
  - OUT: m00_axis_tvalid = 1, tdata = best index, tlast = captured tlast. Held stable until m00_axis_tready, then -> IDLE.
- Latency: the final-beat acceptance edge to the m00_axis_tvalid rise is K+CLASS_NUM+1 cycles (13 at defaults).
- class_sums: hold the previous sample's values until the next SUM entry.
- Input ready without TM_OVERLAP_EN: s_axis_tready = (state == IDLE). No beats are accepted during SUM, ARGMAX or OUT.
- Width rule: the static parameter check fails elaboration if WEIGHT_LENGTH cannot hold ±P/2.

Optional Feature:
- TM_OVERLAP_EN defined:
  - s_axis_tready stays high during SUM, ARGMAX and OUT, so the next sample's beats 0..STAGE_NUM-2 load while the engine works from the snapshot.
  - The final beat (cnt == STAGE_NUM-1) is accepted only when state == IDLE, or when in OUT with m00_axis_tready = 1 in the same cycle.
- Undefined: strictly serial behaviour, as above.

Decomposition:
- Package tm_infer_pkg holds:
  - the state enum (IDLE, SUM, ARGMAX, OUT);
  - derived constants P and K;
  - $clog2 widths for the beat counter, chunk index and class index.
- Sub-module tm_class_argmax: sequential signed argmax with start/done and lowest-index tie rule.

Test Plan:
- Serial sample, defaults: 13 beats with class 3's clauses set to all-positive (sum +10), others 0 -> stage_valid one-hot 0..12; tdata = 3; class_sums[3] = 10; tvalid rises 13 cycles after beat 12.
- Tie: classes 2 and 7 both sum +5 -> tdata = 2.
- Backpressure: hold m00_axis_tready = 0 for 20 cycles -> tvalid and tdata stable; s_axis_tready = 0 throughout (non-overlap); a single transfer on release.
- TLAST: s_axis_tlast on beat 4 of the second sample -> first result tlast = 0, second result tlast = 1.
- Reset: assert rst during SUM cycle 1 -> all outputs 0 next cycle; no result emitted; next full sample classified correctly.
- TM_OVERLAP_EN: back-to-back samples with continuous tvalid and tready -> beats 0..11 of sample 2 accepted during sample 1's processing; the final beat stalls until sample 1's OUT handshake; both results correct and in order.
